// File: rtl/lsc_gain_ctrl.sv
// LSC front-end: raster x/y tracking, per-cell gain lookup and the stage-0 pulse handshake.
// state | meaning:  IDLE | table writable, no pixels accepted;  RUN | frame in progress, table frozen
module lsc_gain_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int GAIN_WIDTH = 12,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int GRID_SHIFT = 6,
    parameter int GRID_COLS  = 10,
    parameter int GRID_ROWS  = 8,
    parameter int ADDR_W     = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    cfg_we,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [3*GAIN_WIDTH-1:0] cfg_data,
    output logic                    cfg_err,
    input  logic                    u_i_ready,
    input  logic [3*DATA_WIDTH-1:0] data_in,
    output logic                    i_i_ready,
    output logic                    i_r_ready,
    output logic [3*DATA_WIDTH-1:0] data_out,
    output logic [3*GAIN_WIDTH-1:0] gain_out,
    output logic                    busy,
    output logic                    frame_done
);
    localparam int N  = GRID_COLS * GRID_ROWS;
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [31:0] N_U = 32'(N);
    localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(256);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic [3*GAIN_WIDTH-1:0] table_q [N];
    logic [3*DATA_WIDTH-1:0] data_out_q;
    logic [3*GAIN_WIDTH-1:0] gain_out_q;
    logic                    i_i_ready_q, i_r_ready_q, busy_q, frame_done_q, cfg_err_q;
    logic [IW-1:0]           cell_idx;
    logic                    insert, last_px, addr_ok;

    assign cell_idx = IW'((32'(y_q) >> GRID_SHIFT) * GRID_COLS + (32'(x_q) >> GRID_SHIFT));
    assign insert   = (state_q == RUN) && u_i_ready && i_i_ready_q;
    assign last_px  = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));
    assign addr_ok  = 32'(cfg_addr) < N_U;

    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_q == XW'(IMG_W - 1)) begin
            x_d = '0;
            y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            data_out_q   <= '0;
            gain_out_q   <= '0;
            i_i_ready_q  <= 1'b0;
            i_r_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            for (int i = 0; i < N; i++) table_q[i] <= {3{UNITY}};
        end else begin
            // The table only changes between frames so every pixel of a frame sees the same gains.
            cfg_err_q <= cfg_we && ((state_q == RUN) || !addr_ok);
            if (cfg_we && (state_q == IDLE) && addr_ok) table_q[IW'(cfg_addr)] <= cfg_data;

            case (state_q)
                IDLE: begin
                    i_i_ready_q  <= 1'b0;
                    i_r_ready_q  <= 1'b0;
                    frame_done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        x_q     <= '0;
                        y_q     <= '0;
                    end
                end
                RUN: begin
                    frame_done_q <= 1'b0;
                    if (insert) begin
                        data_out_q  <= data_in;
                        gain_out_q  <= table_q[cell_idx];
                        i_r_ready_q <= 1'b1;
                        i_i_ready_q <= 1'b0;
                        x_q         <= x_d;
                        y_q         <= y_d;
                        if (last_px) begin
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end else begin
                        i_r_ready_q <= 1'b0;
                        i_i_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign gain_out   = gain_out_q;
    assign i_i_ready  = i_i_ready_q;
    assign i_r_ready  = i_r_ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_lsc_gain_ctrl.sv
// Scoreboard bench for lsc_gain_ctrl on an 8x4 frame with 2x2 cells in a 5x2 table.
module tb_lsc_gain_ctrl;
    localparam int DW = 12, GW = 12, IW = 8, IH = 4, GS = 1, GC = 5, GR = 2, AW = 4;
    localparam int N = GC * GR;
    localparam logic [3*GW-1:0] UNITY3 = {12'd256, 12'd256, 12'd256};

    logic clock = 1'b0;
    logic reset, start, cfg_we, cfg_err, u_i_ready;
    logic [AW-1:0]     cfg_addr;
    logic [3*GW-1:0]   cfg_data;
    logic [3*DW-1:0]   data_in, data_out;
    logic [3*GW-1:0]   gain_out;
    logic i_i_ready, i_r_ready, busy, frame_done;

    lsc_gain_ctrl #(
        .DATA_WIDTH(DW), .GAIN_WIDTH(GW), .IMG_W(IW), .IMG_H(IH),
        .GRID_SHIFT(GS), .GRID_COLS(GC), .GRID_ROWS(GR), .ADDR_W(AW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .u_i_ready(u_i_ready), .data_in(data_in), .i_i_ready(i_i_ready),
        .i_r_ready(i_r_ready), .data_out(data_out), .gain_out(gain_out),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3*DW-1:0] d;
        logic [3*GW-1:0] g;
        logic            last;
    } exp_t;

    exp_t sbq[$];
    int checks = 0, errors = 0;
    int cyc = 0, prev_cyc = 0, pulses = 0, dones = 0;
    bit have_prev = 1'b0;
    logic [3*GW-1:0] btab [N];
    int mx = 0, my = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per output pulse.
    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (i_r_ready) begin
            pulses++;
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pulse: got i_r_ready=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("data_out", 64'(data_out), 64'(e.d));
                chk("gain_out", 64'(gain_out), 64'(e.g));
                chk("frame_done", 64'(frame_done), 64'(e.last));
                chk("busy_during_pulse", 64'(busy), 64'(!e.last));
                chk("i_i_ready_during_pulse", 64'(i_i_ready), 64'(0));
                if (have_prev) chk("pulse_spacing", 64'(cyc - prev_cyc), 64'(2));
                prev_cyc  = cyc;
                have_prev = !e.last;
            end
        end else if (frame_done) begin
            checks++; errors++;
            $display("FAIL stray_frame_done: got frame_done=1 expected 0 without i_r_ready (cycle %0d)", cyc);
        end
        if (frame_done) dones++;
    end

    task automatic send_pixel(input logic [3*DW-1:0] pix);
        int n;
        exp_t e;
        data_in   = pix;
        u_i_ready = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clock);
            if (i_i_ready) break;
            n++;
        end
        if (n == 20) begin
            checks++; errors++;
            $display("FAIL insert_timeout: got i_i_ready=0 for 20 cycles expected 1");
            return;
        end
        e.d    = pix;
        e.g    = btab[(my >> GS) * GC + (mx >> GS)];
        e.last = (mx == IW - 1) && (my == IH - 1);
        sbq.push_back(e);
        if (mx == IW - 1) begin
            mx = 0;
            my = (my == IH - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
        @(posedge clock); #1;
    endtask

    task automatic cfg_write(input int a, input logic [3*GW-1:0] d, input bit exp_err);
        @(posedge clock); #1;
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = d;
        @(posedge clock); #1;
        cfg_we = 1'b0;
        chk("cfg_err", 64'(cfg_err), 64'(exp_err));
        if (!exp_err) btab[a] = d;
    endtask

    task automatic start_frame(input bit w, input int a, input logic [3*GW-1:0] d);
        @(posedge clock); #1;
        start = 1'b1;
        if (w) begin
            cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = d;
        end
        @(posedge clock); #1;
        start = 1'b0; cfg_we = 1'b0;
        if (w) begin
            chk("cfg_err_with_start", 64'(cfg_err), 64'(0));
            btab[a] = d;
        end
        have_prev = 1'b0;
        pulses = 0;
        mx = 0; my = 0;
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("i_i_ready_first_run_cycle", 64'(i_i_ready), 64'(0));
        @(posedge clock); #1;
        chk("i_i_ready_second_run_cycle", 64'(i_i_ready), 64'(1));
    endtask

    task automatic run_frame(input int first_k);
        int d0;
        d0 = dones;
        for (int k = first_k; k < IW * IH; k++)
            send_pixel({12'(100 + k), 12'(200 + k), 12'(300 + k)});
        u_i_ready = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("frame_pulses", 64'(pulses), 64'(IW * IH - first_k));
        chk("frame_done_count", 64'(dones - d0), 64'(1));
        chk("busy_after_frame", 64'(busy), 64'(0));
        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        u_i_ready = 1'b1; data_in = 36'h123456789;
        for (int i = 0; i < N; i++) btab[i] = UNITY3;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Idle with upstream valid asserted: nothing may be consumed or emitted.
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            chk("idle_outputs",
                64'({data_out, gain_out, i_i_ready, i_r_ready, busy, frame_done, cfg_err}), 64'(0));
        end
        u_i_ready = 1'b0;

        // Unity frame; first pixel {100,200,300} at (0,0).
        start_frame(1'b0, 0, '0);
        run_frame(0);

        // Table writes: in range, out of range, then a write coinciding with start.
        cfg_write(6, {12'd512, 12'd256, 12'd128}, 1'b0);
        cfg_write(10, {12'd1, 12'd2, 12'd3}, 1'b1);
        cfg_write(15, {12'd4, 12'd5, 12'd6}, 1'b1);
        start_frame(1'b1, 0, {12'd300, 12'd128, 12'd64});
        cfg_write(6, {12'd7, 12'd7, 12'd7}, 1'b1);
        run_frame(0);

        // Mid-frame reset: abort, no frame_done, table back to unity.
        start_frame(1'b0, 0, '0);
        for (int k = 0; k < 5; k++)
            send_pixel({12'(100 + k), 12'(200 + k), 12'(300 + k)});
        u_i_ready = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        d0 = dones;
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        have_prev = 1'b0;
        chk("reset_no_frame_done", 64'(dones - d0), 64'(0));
        chk("reset_pulses_seen", 64'(pulses), 64'(5));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_i_i_ready", 64'(i_i_ready), 64'(0));
        for (int i = 0; i < N; i++) btab[i] = UNITY3;
        start_frame(1'b0, 0, '0);
        run_frame(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsc_gain_ctrl.md
Name: lsc_gain_ctrl

Overview:
- Front-end controller for the 4-stage LSC pipeline (multiply, round, shift, clamp).
- Holds a coarse per-region gain table loaded over a config port.
- Tracks raster x/y position across a frame and pairs each accepted RGB pixel with the gain triple of its grid cell.
- Issues the data/gain pair to LSC stage 0 using the codebase's ready handshake.

Parameters:
- DATA_WIDTH, 12, bits per colour channel of pixel data
- GAIN_WIDTH, 12, bits per colour gain (Q4.8, 256 = unity)
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- GRID_SHIFT, 6, log2 of grid cell edge in pixels (64x64 cells)
- GRID_COLS, 10, table columns, must be at least ceil(IMG_W / 2^GRID_SHIFT)
- GRID_ROWS, 8, table rows, must be at least ceil(IMG_H / 2^GRID_SHIFT)
- ADDR_W, 7, config address width, must be at least clog2(GRID_COLS*GRID_ROWS)

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle frame start request
- cfg_we  input  1  table write strobe
- cfg_addr  input  ADDR_W  table index, row*GRID_COLS+col
- cfg_data  input  3*GAIN_WIDTH  {gR,gG,gB}
- cfg_err  output  1  pulse: write rejected
- u_i_ready  input  1  upstream pixel valid
- data_in  input  3*DATA_WIDTH  {R,G,B} pixel
- i_i_ready  output  1  block can accept a pixel this cycle
- i_r_ready  output  1  data_out/gain_out valid (one-cycle pulse)
- data_out  output  3*DATA_WIDTH  registered pixel to LSC stage 0
- gain_out  output  3*GAIN_WIDTH  registered gain to LSC stage 0
- busy  output  1  high in RUN
- frame_done  output  1  pulse after last pixel of frame issued

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Port names are clock and reset.
- Reset values:
  - state=IDLE; x=y=0.
  - i_i_ready=0, i_r_ready=0, busy=0, frame_done=0, cfg_err=0.
  - data_out=0, gain_out=0.
  - All GRID_COLS*GRID_ROWS table entries = {256,256,256}.
  - Reset mid-frame aborts the frame with no frame_done and restores the unity table.
- States: IDLE, RUN.
  - IDLE: i_i_ready=0. start -> RUN next cycle, x=y=0, busy=1.
  - RUN: start is ignored.
- Handshake (RUN):
  - insert = u_i_ready && i_i_ready.
  - On insert, next cycle: data_out <= data_in; gain_out <= table[(y>>GRID_SHIFT)*GRID_COLS + (x>>GRID_SHIFT)]; i_r_ready=1; i_i_ready=0.
  - Any non-insert cycle in RUN: i_r_ready=0, i_i_ready=1.
  - Peak rate is one pixel per 2 cycles, matching LSC stage cadence. Latency from insert to i_r_ready is 1 cycle.
  - i_i_ready rises the cycle after entering RUN.
  - No downstream backpressure: the LSC stages always accept on the pulse.
- Counters: advance only on insert.
  - x increments; at x=IMG_W-1, x wraps to 0 and y increments.
  - At insert with x=IMG_W-1 and y=IMG_H-1: next cycle outputs that pixel, frame_done=1 for one cycle, state->IDLE, busy=0, i_i_ready=0, x=y=0.
  - u_i_ready while IDLE is ignored; no pixel consumed.
- Config:
  - In IDLE, cfg_we writes cfg_data to table[cfg_addr] at the clock edge.
  - cfg_addr >= GRID_COLS*GRID_ROWS is dropped and cfg_err pulses next cycle.
  - In RUN, writes are dropped and cfg_err pulses next cycle; the table is frozen per frame.
  - cfg_we in the same cycle as start (IDLE): the write takes effect and the frame starts.
- Index arithmetic: x is clog2(IMG_W) bits and y is clog2(IMG_H) bits, unsigned. The index multiply is a constant multiply. The table read is combinational from registers.

Test Plan:
- Reset then idle: all outputs 0, i_i_ready=0 for 10 cycles; u_i_ready=1 during IDLE consumes nothing, and x/y stay 0 at start.
- Unity table, start, pixel {100,200,300} at (0,0) -> next cycle i_r_ready=1, data_out={100,200,300}, gain_out={256,256,256}, i_i_ready=0; following cycle i_i_ready=1.
- Write table[11]={512,256,128} in IDLE, run frame -> pixel (64,64) gets gain_out={512,256,128}; pixels (63,64) and (64,63) get unity.
- Continuous u_i_ready=1, IMG_W=8, IMG_H=4, GRID_SHIFT=2 -> exactly 32 i_r_ready pulses spaced 2 cycles; frame_done one cycle, coincident with the 32nd i_r_ready; busy falls then; x wraps every 8 pixels.
- cfg_we during RUN, or cfg_addr=80 in IDLE -> cfg_err pulse, table unchanged (verify by readback through a following frame).
- Reset asserted after 5 pixels of a frame -> IDLE, no frame_done, table back to unity; new start begins at (0,0).
